ravan_axi_initiator: RTL and testbench
======================================

// Module: ravan_axi_initiator
// PURPOSE
//  Initiator-side sequencer for the RAVAN crypto slave's AXI-style handshake. Accepts one
//  encrypt job (addr/data/key) on a valid/ready request port, runs AW -> W -> B -> AR -> R
//  on the slave's five channels, captures the 64-bit result and SHA error flag, and returns
//  them on a valid/ready response port. Per-channel watchdog aborts a hung transaction.
// PARAMETERS
//  ADDR_W    16   address width driven on m_address
//  DATA_W    64   payload/result width
//  KEY_W     512  key width driven on m_key
//  TIMEOUT   255  max cycles waited in any handshake state before abort (1..65535)
// PORTS
//  clk          in   1       clock, all logic on rising edge
//  rst          in   1       asynchronous, active-low reset
//  req_valid    in   1       job request valid
//  req_ready    out  1       high only in IDLE
//  req_addr     in   ADDR_W  job address
//  req_data     in   DATA_W  plaintext block
//  req_key      in   KEY_W   key
//  rsp_valid    out  1       result valid, held until rsp_ready
//  rsp_ready    in   1       result consumed
//  rsp_data     out  DATA_W  result block (0 on timeout)
//  rsp_error    out  1       captured s_sha_error
//  rsp_timeout  out  1       watchdog abort flag
//  m_address    out  ADDR_W  registered job address to slave
//  m_data       out  DATA_W  registered job data to slave
//  m_key        out  KEY_W   registered job key to slave
//  awvalid/wvalid/arvalid/bready/rready  out 1  channel controls to slave
//  awready/wready/arready/bvalid/rvalid  in  1  channel responses from slave
//  s_data       in   DATA_W  slave result register
//  s_sha_error  in   1       slave SHA error
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, timer 0; job regs cleared. Reset mid-job abandons it.
//  All outputs registered. States and transitions:
//   IDLE: req_ready=1. req_valid -> latch addr/data/key into m_*, go AW, req_ready->0.
//   AW : awvalid=1 until awvalid&awready sampled high -> awvalid 0, go W.
//   W  : wvalid=1 until wvalid&wready -> wvalid 0, go B.
//   B  : wait bvalid; first cycle bvalid seen -> bready=1 for exactly one cycle, go AR.
//        bready never asserted before bvalid (slave exits write phase on bready alone).
//   AR : arvalid=1 until arvalid&arready -> arvalid 0, go R.
//   R  : wait rvalid; when seen -> rready=1 for exactly one cycle, go CAP.
//   CAP: one cycle later sample s_data/s_sha_error (slave registers result on rready) ->
//        rsp_data, rsp_error; rsp_valid=1, go RSP.
//   RSP: hold rsp_* stable; rsp_valid&rsp_ready -> rsp_valid 0, go IDLE (next job accepted
//        no earlier than the following cycle).
//  Watchdog: 16-bit timer cleared on every state change, increments in AW/W/B/AR/R.
//   timer==TIMEOUT-1 without completing -> drop all valids/readys, rsp_data=0,
//   rsp_error=0, rsp_timeout=1, rsp_valid=1, go RSP. rsp_timeout cleared on next accept.
//  Handshake completing on the timeout cycle wins (no abort).
//  m_address/m_data/m_key stable from accept until next accept.
//  Minimum latency req accept -> rsp_valid with single-cycle slave responses: 8 cycles plus
//   slave internal wait states.
//  One job in flight; no pipelining, no retry.
// TESTING
//  1 Nominal: req addr=0x0010, data=0x0123456789ABCDEF, key=all 0xA5 against slave model ->
//    rsp_valid once, rsp_data=model result, rsp_error=0, rsp_timeout=0; order AW,W,B,AR,R.
//  2 Protocol: slave model asserting bvalid 3 cycles late -> bready low until bvalid, then
//    exactly one-cycle pulse; rready likewise a single pulse after rvalid.
//  3 Timeout: TIMEOUT=8, awready tied 0 -> after 8 AW cycles awvalid drops, rsp_valid=1,
//    rsp_timeout=1, rsp_data=0; next job completes normally with rsp_timeout=0.
//  4 Backpressure: rsp_ready low 5 cycles -> rsp_* stable, req_ready stays 0 throughout;
//    second req_valid held high accepted only after response consumed.
//  5 Error path: slave s_sha_error=1 at result -> rsp_error=1, rsp_data=s_data.
//  6 Reset mid-job: rst low during AR -> all outputs 0 asynchronously, IDLE after release,
//    fresh job completes correctly.

Source files
------------

// File: rtl/ravan_axi_initiator.sv
// rtl/ravan_axi_initiator.sv - single-job AW/W/B/AR/R sequencer for the RAVAN crypto slave
module ravan_axi_initiator #(
   parameter int ADDR_W  = 16,
   parameter int DATA_W  = 64,
   parameter int KEY_W   = 512,
   parameter int TIMEOUT = 255
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_data,
   input  logic [KEY_W-1:0]  req_key,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_data,
   output logic              rsp_error,
   output logic              rsp_timeout,
   output logic [ADDR_W-1:0] m_address,
   output logic [DATA_W-1:0] m_data,
   output logic [KEY_W-1:0]  m_key,
   output logic              awvalid,
   output logic              wvalid,
   output logic              arvalid,
   output logic              bready,
   output logic              rready,
   input  logic              awready,
   input  logic              wready,
   input  logic              arready,
   input  logic              bvalid,
   input  logic              rvalid,
   input  logic [DATA_W-1:0] s_data,
   input  logic              s_sha_error
);

   typedef enum logic [2:0] {
      S_IDLE, S_AW, S_W, S_B, S_AR, S_R, S_CAP, S_RSP
   } state_t;

   // Last timer value allowed in a handshake state before the job is abandoned.
   localparam logic [15:0] TMAX = 16'(TIMEOUT - 1);

   state_t            state, state_nx;
   logic [15:0]       timer, timer_nx;
   logic              watched;

   logic              req_ready_nx, rsp_valid_nx, rsp_error_nx, rsp_timeout_nx;
   logic [DATA_W-1:0] rsp_data_nx, m_data_nx;
   logic [ADDR_W-1:0] m_address_nx;
   logic [KEY_W-1:0]  m_key_nx;
   logic              awvalid_nx, wvalid_nx, arvalid_nx, bready_nx, rready_nx;

   // State register plus every output flop; reset abandons any job in flight.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= S_IDLE;
         timer       <= '0;
         req_ready   <= 1'b0;
         rsp_valid   <= 1'b0;
         rsp_data    <= '0;
         rsp_error   <= 1'b0;
         rsp_timeout <= 1'b0;
         m_address   <= '0;
         m_data      <= '0;
         m_key       <= '0;
         awvalid     <= 1'b0;
         wvalid      <= 1'b0;
         arvalid     <= 1'b0;
         bready      <= 1'b0;
         rready      <= 1'b0;
      end else begin
         state       <= state_nx;
         timer       <= timer_nx;
         req_ready   <= req_ready_nx;
         rsp_valid   <= rsp_valid_nx;
         rsp_data    <= rsp_data_nx;
         rsp_error   <= rsp_error_nx;
         rsp_timeout <= rsp_timeout_nx;
         m_address   <= m_address_nx;
         m_data      <= m_data_nx;
         m_key       <= m_key_nx;
         awvalid     <= awvalid_nx;
         wvalid      <= wvalid_nx;
         arvalid     <= arvalid_nx;
         bready      <= bready_nx;
         rready      <= rready_nx;
      end
   end

   // Next state and next output values; bready/rready default low so they only ever pulse.
   always_comb begin
      state_nx       = state;
      rsp_valid_nx   = rsp_valid;
      rsp_data_nx    = rsp_data;
      rsp_error_nx   = rsp_error;
      rsp_timeout_nx = rsp_timeout;
      m_address_nx   = m_address;
      m_data_nx      = m_data;
      m_key_nx       = m_key;
      awvalid_nx     = awvalid;
      wvalid_nx      = wvalid;
      arvalid_nx     = arvalid;
      bready_nx      = 1'b0;
      rready_nx      = 1'b0;
      watched        = 1'b0;

      case (state)
         S_IDLE: begin
            if (req_ready && req_valid) begin
               m_address_nx   = req_addr;
               m_data_nx      = req_data;
               m_key_nx       = req_key;
               rsp_timeout_nx = 1'b0;
               awvalid_nx     = 1'b1;
               state_nx       = S_AW;
            end
         end
         S_AW: begin
            watched = 1'b1;
            if (awvalid && awready) begin
               awvalid_nx = 1'b0;
               wvalid_nx  = 1'b1;
               state_nx   = S_W;
            end
         end
         S_W: begin
            watched = 1'b1;
            if (wvalid && wready) begin
               wvalid_nx = 1'b0;
               state_nx  = S_B;
            end
         end
         S_B: begin
            // The slave leaves its write phase on bready alone, so only answer a seen bvalid.
            watched = 1'b1;
            if (bvalid) begin
               bready_nx  = 1'b1;
               arvalid_nx = 1'b1;
               state_nx   = S_AR;
            end
         end
         S_AR: begin
            watched = 1'b1;
            if (arvalid && arready) begin
               arvalid_nx = 1'b0;
               state_nx   = S_R;
            end
         end
         S_R: begin
            watched = 1'b1;
            if (rvalid) begin
               rready_nx = 1'b1;
               state_nx  = S_CAP;
            end
         end
         S_CAP: begin
            // The slave registers its result on the rready edge, so sample one cycle after it.
            if (!rready) begin
               rsp_data_nx  = s_data;
               rsp_error_nx = s_sha_error;
               rsp_valid_nx = 1'b1;
               state_nx     = S_RSP;
            end
         end
         S_RSP: begin
            if (rsp_valid && rsp_ready) begin
               rsp_valid_nx = 1'b0;
               state_nx     = S_IDLE;
            end
         end
         default: state_nx = S_IDLE;
      endcase

      // A handshake completing on the last allowed cycle has already moved state_nx on.
      if (watched && (state_nx == state) && (timer == TMAX)) begin
         awvalid_nx     = 1'b0;
         wvalid_nx      = 1'b0;
         arvalid_nx     = 1'b0;
         bready_nx      = 1'b0;
         rready_nx      = 1'b0;
         rsp_data_nx    = '0;
         rsp_error_nx   = 1'b0;
         rsp_timeout_nx = 1'b1;
         rsp_valid_nx   = 1'b1;
         state_nx       = S_RSP;
      end

      timer_nx     = ((state_nx != state) || !watched) ? 16'd0 : 16'(timer + 16'd1);
      req_ready_nx = (state_nx == S_IDLE);
   end

endmodule

// File: tb/tb_ravan_axi_initiator.sv
// tb/tb_ravan_axi_initiator.sv - self-checking bench for ravan_axi_initiator
module tb_ravan_axi_initiator;

   localparam logic [63:0] STALE = 64'hDEAD_BEEF_0BAD_F00D;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         req_valid = 1'b0;
   logic         req_ready;
   logic [15:0]  req_addr = '0;
   logic [63:0]  req_data = '0;
   logic [511:0] req_key = '0;
   logic         rsp_valid;
   logic         rsp_ready = 1'b0;
   logic [63:0]  rsp_data;
   logic         rsp_error, rsp_timeout;
   logic [15:0]  m_address;
   logic [63:0]  m_data;
   logic [511:0] m_key;
   logic         awvalid, wvalid, arvalid, bready, rready;
   logic         awready = 1'b0, wready = 1'b0, arready = 1'b0;
   logic         bvalid = 1'b0, rvalid = 1'b0;
   logic [63:0]  s_data = STALE;
   logic         s_sha_error = 1'b0;

   always #5 clk = ~clk;

   ravan_axi_initiator #(.ADDR_W(16), .DATA_W(64), .KEY_W(512), .TIMEOUT(8)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_addr(req_addr), .req_data(req_data), .req_key(req_key),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
      .rsp_error(rsp_error), .rsp_timeout(rsp_timeout),
      .m_address(m_address), .m_data(m_data), .m_key(m_key),
      .awvalid(awvalid), .wvalid(wvalid), .arvalid(arvalid),
      .bready(bready), .rready(rready),
      .awready(awready), .wready(wready), .arready(arready),
      .bvalid(bvalid), .rvalid(rvalid),
      .s_data(s_data), .s_sha_error(s_sha_error)
   );

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // The slave's "encryption": any fixed mix of address, data and key will do.
   function automatic logic [63:0] slave_fn(input logic [15:0] a, input logic [63:0] d,
                                            input logic [511:0] k);
      return (d ^ k[63:0]) + {48'b0, a};
   endfunction

   // Slave model knobs and state
   bit aw_stall = 0;
   bit sha_err  = 0;
   int b_delay  = 0;
   int r_delay  = 0;
   int b_cnt    = -1;
   int r_cnt    = -1;
   bit hs_aw = 0, hs_w = 0, hs_b = 0, hs_ar = 0, hs_r = 0;
   int ev_log[$];

   // Slave: applies last edge's handshakes, then drives its signals for the next edge.
   initial forever begin
      @(negedge clk);
      if (!rst) begin
         awready = 0; wready = 0; arready = 0; bvalid = 0; rvalid = 0;
         b_cnt = -1; r_cnt = -1;
         hs_aw = 0; hs_w = 0; hs_b = 0; hs_ar = 0; hs_r = 0;
      end else begin
         if (hs_aw) begin ev_log.push_back(1); s_data = STALE; s_sha_error = 0; end
         if (hs_w)  begin ev_log.push_back(2); b_cnt = b_delay; end
         if (hs_b)  begin ev_log.push_back(3); bvalid = 0; end
         if (hs_ar) begin ev_log.push_back(4); r_cnt = r_delay; end
         if (hs_r) begin
            ev_log.push_back(5);
            rvalid = 0;
            s_data = slave_fn(m_address, m_data, m_key);
            s_sha_error = sha_err;
         end
         if (b_cnt == 0) begin bvalid = 1; b_cnt = -1; end
         else if (b_cnt > 0) b_cnt--;
         if (r_cnt == 0) begin rvalid = 1; r_cnt = -1; end
         else if (r_cnt > 0) r_cnt--;
         awready = !aw_stall;
         wready  = 1;
         arready = 1;
         hs_aw = awvalid && awready;
         hs_w  = wvalid && wready;
         hs_b  = bvalid && bready;
         hs_ar = arvalid && arready;
         hs_r  = rvalid && rready;
      end
   end

   // Reference model: one job in flight, response determined by the job and slave knobs.
   bit           busy = 0;
   logic [15:0]  job_a;
   logic [63:0]  job_d;
   logic [511:0] job_k;
   logic [63:0]  exp_d;
   bit           exp_e, exp_t;
   int           aw_cycles = 0;
   int           accepts = 0;
   bit           prev_bv = 0, prev_br = 0, prev_rv = 0, prev_rr = 0;

   // Compare process: samples mid-cycle, checks outputs against the model every cycle.
   initial forever begin
      @(negedge clk);
      #2;
      if (!rst) begin
         busy = 0;
         prev_bv = 0; prev_br = 0; prev_rv = 0; prev_rr = 0;
      end else begin
         if (bready) check("bready_pulse", {prev_bv, bvalid, prev_br}, 3'b110);
         if (rready) check("rready_pulse", {prev_rv, rvalid, prev_rr}, 3'b110);
         if (busy) begin
            check("req_ready_busy", req_ready, 1'b0);
            check("m_address", m_address, job_a);
            check("m_data", m_data, job_d);
            check("m_key", m_key, job_k);
         end
         if (rsp_valid) begin
            check("rsp_while_busy", busy, 1'b1);
            check("rsp_data", rsp_data, exp_d);
            check("rsp_error", rsp_error, exp_e);
            check("rsp_timeout", rsp_timeout, exp_t);
         end
         prev_bv = bvalid; prev_br = bready; prev_rv = rvalid; prev_rr = rready;
         if (awvalid) aw_cycles++;
         if (rsp_valid && rsp_ready) busy = 0;
         if (req_valid && req_ready) begin
            busy  = 1;
            job_a = req_addr; job_d = req_data; job_k = req_key;
            exp_t = aw_stall;
            exp_d = aw_stall ? 64'h0 : slave_fn(req_addr, req_data, req_key);
            exp_e = aw_stall ? 1'b0 : sha_err;
            aw_cycles = 0;
            accepts++;
         end
      end
   end

   logic [63:0] got_d;
   logic        got_e, got_t;

   task automatic wait_ready();
      int n = 0;
      while (!req_ready && n < 100) begin @(negedge clk); n++; end
      check("accept_in_time", req_ready, 1'b1);
   endtask

   task automatic wait_rsp();
      int n = 0;
      while (!rsp_valid && n < 200) begin @(negedge clk); n++; end
      check("rsp_in_time", rsp_valid, 1'b1);
   endtask

   task automatic take_rsp(input int hold);
      repeat (hold) @(negedge clk);
      got_d = rsp_data; got_e = rsp_error; got_t = rsp_timeout;
      rsp_ready = 1;
      @(negedge clk);
      rsp_ready = 0;
   endtask

   task automatic do_job(input logic [15:0] a, input logic [63:0] d, input logic [511:0] k,
                         input int hold);
      ev_log.delete();
      req_addr = a; req_data = d; req_key = k; req_valid = 1;
      wait_ready();
      @(negedge clk);
      req_valid = 0;
      wait_rsp();
      take_rsp(hold);
   endtask

   task automatic check_order();
      check("log_len", ev_log.size(), 5);
      if (ev_log.size() == 5)
         for (int i = 0; i < 5; i++) check("log_order", ev_log[i], i + 1);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_ctrl"}, {req_ready, rsp_valid, rsp_error, rsp_timeout,
                             awvalid, wvalid, arvalid, bready, rready}, '0);
      check({tag, "_data"}, {rsp_data, m_address, m_data}, '0);
      check({tag, "_key"}, m_key, '0);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1);
   end

   initial begin
      int n;
      int acc0;
      repeat (3) @(negedge clk);
      check_all_zero("reset");
      rst = 1;
      @(negedge clk);
      check("ready_after_reset", req_ready, 1'b1);

      // 1 nominal
      do_job(16'h0010, 64'h0123_4567_89AB_CDEF, {64{8'hA5}}, 2);
      check("t1_data", got_d, 64'hA486_E0C2_2C0E_685A);
      check("t1_err", got_e, 1'b0);
      check("t1_to", got_t, 1'b0);
      check("t1_aw_cycles", aw_cycles, 1);
      check_order();

      // 2 late bvalid / rvalid
      b_delay = 3; r_delay = 3;
      do_job(16'h0020, 64'h0, '0, 0);
      check("t2_data", got_d, 64'h20);
      check("t2_to", got_t, 1'b0);
      check_order();
      b_delay = 0; r_delay = 0;

      // 3 watchdog on a stuck AW channel, then a clean job
      aw_stall = 1;
      do_job(16'h0030, 64'h1234, '0, 0);
      check("t3_to", got_t, 1'b1);
      check("t3_data", got_d, 64'h0);
      check("t3_aw_cycles", aw_cycles, 8);
      check("t3_no_handshakes", ev_log.size(), 0);
      aw_stall = 0;
      do_job(16'h0031, 64'h1000, '0, 0);
      check("t3b_to", got_t, 1'b0);
      check("t3b_data", got_d, 64'h1031);

      // 4 response backpressure with a second request waiting
      req_addr = 16'h0100; req_data = 64'h1111_2222_3333_4444; req_key = '0; req_valid = 1;
      wait_ready();
      @(negedge clk);
      acc0 = accepts;
      req_addr = 16'h0200; req_data = 64'h5555_6666_7777_8888;
      wait_rsp();
      repeat (5) @(negedge clk);
      check("t4_req_ready", req_ready, 1'b0);
      check("t4_hold_data", rsp_data, 64'h1111_2222_3333_4544);
      check("t4_hold_valid", rsp_valid, 1'b1);
      rsp_ready = 1;
      @(negedge clk);
      rsp_ready = 0;
      check("t4_no_early_accept", accepts, acc0);
      wait_ready();
      @(negedge clk);
      req_valid = 0;
      wait_rsp();
      take_rsp(0);
      check("t4_second_data", got_d, 64'h5555_6666_7777_8A88);

      // 5 SHA error reported with the data
      sha_err = 1;
      do_job(16'h1234, 64'h0, '0, 1);
      check("t5_err", got_e, 1'b1);
      check("t5_data", got_d, 64'h1234);
      sha_err = 0;

      // 6 reset during AR, then a fresh job
      req_addr = 16'h00AA; req_data = 64'hFFFF_0000_FFFF_0000; req_key = '0; req_valid = 1;
      n = 0;
      while (!arvalid && n < 50) begin @(negedge clk); n++; end
      check("t6_reached_ar", arvalid, 1'b1);
      #1 rst = 0;
      #1 check_all_zero("t6_async");
      req_valid = 0;
      repeat (2) @(negedge clk);
      rst = 1;
      do_job(16'h0055, 64'h0F0F_0F0F_0F0F_0F0F, {64{8'hA5}}, 0);
      check("t6_data", got_d, 64'hAAAA_AAAA_AAAA_AAFF);
      check("t6_to", got_t, 1'b0);
      check_order();

      repeat (3) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
